// File: rtl/nibble_serial_adder.sv
// Multi-cycle wide adder: one 4-bit nibble per clock, carry held in a register between nibbles.
// Optional signed-overflow output enabled by defining NIBBLE_SERIAL_ADDER_OVF_EN.
module nibble_serial_adder #(
  parameter int N_NIBBLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*N_NIBBLES-1:0] a,
  input  logic [4*N_NIBBLES-1:0] b,
  input  logic                   cin,
  output logic                   busy,
  output logic                   done,
  output logic [4*N_NIBBLES-1:0] sum,
  output logic                   cout
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  ,
  output logic                   ovf
`endif
);

  localparam int W = 4 * N_NIBBLES;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]   state;
  logic [W-1:0] a_r;
  logic [W-1:0] b_r;
  logic [W-1:0] work_r;
  logic         carry_r;
  logic [2:0]   idx;

  logic [3:0]   a_nib;
  logic [3:0]   b_nib;
  logic [4:0]   t;
  logic         last;
  logic [W-1:0] final_sum;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < N_NIBBLES; i++) begin
      if (idx == 3'(i)) begin
        a_nib = a_r[4*i +: 4];
        b_nib = b_r[4*i +: 4];
      end
    end
    t    = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_r};
    last = (idx == 3'(N_NIBBLES - 1));
    // Top nibble is written straight into the result, never into work_r first.
    final_sum           = work_r;
    final_sum[W-1 -: 4] = t[3:0];
  end

  assign busy = (state == RUN);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      work_r  <= '0;
      carry_r <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= cin;
            idx     <= '0;
            work_r  <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < N_NIBBLES; i++) begin
            if (idx == 3'(i)) work_r[4*i +: 4] <= t[3:0];
          end
          carry_r <= t[4];
          idx     <= idx + 3'd1;
          if (last) begin
            sum   <= final_sum;
            cout  <= t[4];
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  // Carry into the MSB comes from the low three bits of the top nibble.
  logic [3:0] low3;
  assign low3 = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b000, carry_r};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (state == RUN && last) begin
      ovf <= low3[3] ^ t[4];
    end
  end
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (N_NIBBLES=2): arithmetic model with a
// per-cycle compare process plus hand-computed expectations.
module tb_nibble_serial_adder;

  localparam int N = 2;
  localparam int W = 4 * N;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic         cin   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy, done, cout;
  logic [W-1:0] sum;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  nibble_serial_adder #(.N_NIBBLES(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: result is simply a+b+cin, published N cycles after acceptance.
  logic         m_busy = 1'b0, m_done = 1'b0, m_cout = 1'b0, m_ovf = 1'b0, m_povf = 1'b0;
  logic [W-1:0] m_sum = '0;
  logic [W:0]   m_pend = '0;
  int           m_cnt = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_cout = 1'b0; m_ovf = 1'b0;
      m_sum  = '0;   m_cnt  = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          {m_cout, m_sum} = m_pend;
          m_ovf = m_povf;
        end
      end else if (start) begin
        m_pend = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        m_povf = (a[W-1] == b[W-1]) && (m_pend[W-1] != a[W-1]);
        m_busy = 1'b1;
        m_cnt  = N;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp.busy", busy, m_busy);
      check("cmp.done", done, m_done);
      check("cmp.sum",  sum,  m_sum);
      check("cmp.cout", cout, m_cout);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      check("cmp.ovf",  ovf,  m_ovf);
`endif
    end
  end

  // From the negedge after acceptance, wait (bounded) for done; counts busy cycles.
  task automatic wait_done(input string nm, output int busy_cycles);
    bit seen = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      busy_cycles += int'(busy);
      @(negedge clk);
    end
    check({nm, ".done_seen"}, seen, 1'b1);
  endtask

  task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                       input logic [W-1:0] es, input logic ec, input logic eo,
                       input string nm, output int busy_cycles);
    @(negedge clk);
    a = xa; b = xb; cin = xc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(nm, busy_cycles);
    check({nm, ".sum"},  sum,  es);
    check({nm, ".cout"}, cout, ec);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    check({nm, ".ovf"},  ovf,  eo);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    int n;
    int extra;

    repeat (2) @(negedge clk);
    check("reset.busy", busy, 1'b0);
    check("reset.done", done, 1'b0);
    check("reset.sum",  sum,  8'h00);
    check("reset.cout", cout, 1'b0);
    rst = 1'b0;
    cmp_en = 1'b1;

    do_op(8'h66, 8'h44, 1'b0, 8'hAA, 1'b0, 1'b1, "basic", bc);
    check("basic.busy_cycles", bc, 2);
    do_op(8'h88, 8'h99, 1'b1, 8'h22, 1'b1, 1'b1, "chain", bc);
    do_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, "nibcarry", bc);
    do_op(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, "wrap", bc);
    do_op(8'h70, 8'h10, 1'b0, 8'h80, 1'b0, 1'b1, "ovf_pos", bc);
    do_op(8'hF0, 8'h20, 1'b0, 8'h10, 1'b1, 1'b0, "ovf_none", bc);

    // Back-to-back: start raised during the done cycle.
    do_op(8'hEE, 8'h22, 1'b0, 8'h10, 1'b1, 1'b0, "b2b_first", bc);
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (done) break;
    end
    check("b2b.latency", n, 3);
    check("b2b.sum",  sum,  8'h02);
    check("b2b.cout", cout, 1'b0);

    // Start while busy is ignored.
    @(negedge clk);
    a = 8'h33; b = 8'h11; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start", bc);
    check("busy_start.sum",  sum,  8'h44);
    check("busy_start.cout", cout, 1'b0);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      extra += int'(done);
    end
    check("busy_start.extra_done", extra, 0);

    // Reset one cycle into an operation.
    @(negedge clk);
    a = 8'hAB; b = 8'hCD; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_mid.busy", busy, 1'b0);
    check("rst_mid.done", done, 1'b0);
    check("rst_mid.sum",  sum,  8'h00);
    check("rst_mid.cout", cout, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      extra += int'(done);
    end
    check("rst_mid.no_done", extra, 0);
    do_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, "after_rst", bc);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle adder that performs a wide addition one 4-bit nibble per clock, carrying between nibbles through a register.
- Sits around our 4-bit full-adder stage. It sequences operand nibbles into a nibble-wide add, then collects the nibble sums and the final carry into a registered result.
- It is the next stage up from the combinational 4-bit adder: a sequenced, handshaked wide adder for datapaths that cannot afford a full-width carry chain.

Parameters:
- N_NIBBLES, default 2, number of 4-bit nibbles per operand (operand width W = 4*N_NIBBLES); legal range 1..8.

Ports:
- clk    input   1  single system clock; all state changes on the rising edge.
- rst    input   1  asynchronous, active-high reset.
- start  input   1  request to begin an addition; sampled only when idle.
- a      input   W  operand A; sampled on the accepting edge.
- b      input   W  operand B; sampled on the accepting edge.
- cin    input   1  carry-in to nibble 0; sampled on the accepting edge.
- busy   output  1  high while an addition is in progress.
- done   output  1  single-cycle pulse: sum/cout just updated.
- sum    output  W  registered result, low W bits of a+b+cin.
- cout   output  1  registered carry-out of the top nibble.

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0; all internal operand, carry, counter and working registers are 0.
- FSM states and transitions:
  - IDLE: busy=0. On an edge with start=1:
    - latch a, b into operand registers;
    - carry_r <= cin; idx <= 0; clear the working result register;
    - go to RUN.
  - start=0 in IDLE: remain in IDLE.
  - RUN: busy=1. Each edge:
    - t = a_nib[idx] + b_nib[idx] + carry_r, computed 5 bits wide;
    - work[idx] <= t[3:0]; carry_r <= t[4]; idx <= idx+1.
  - Last nibble (idx == N_NIBBLES-1): on that edge, sum <= the completed working value with the top nibble inserted; cout <= t[4]; done <= 1; state <= IDLE.
- Latency: start sampled at edge k. Nibbles are processed at edges k+1..k+N_NIBBLES. done is high for the cycle after edge k+N_NIBBLES, then cleared at the next edge.
- Throughput: one result per N_NIBBLES+1 cycles. Back-to-back is allowed: start=1 during the done cycle is accepted.
- Output holding:
  - sum and cout change only on a completing edge and hold between operations.
  - Intermediate nibbles never appear on sum.
- start while busy=1 is ignored. No queuing, no error flag. The inputs a, b and cin may change freely during RUN.
- Arithmetic:
  - unsigned, modulo 2^W;
  - {cout,sum} = a + b + cin exactly;
  - carry propagates between nibbles only through carry_r.
- N_NIBBLES=1: a single RUN cycle; done asserts at edge k+1.
- Reset mid-operation:
  - immediately forces IDLE and zeroes all outputs;
  - done is not asserted for the aborted operation;
  - the partial result is discarded.
- No combinational path from any input to any output.

Optional Feature:
- Macro: NIBBLE_SERIAL_ADDER_OVF_EN.
- Defined:
  - adds output port ovf (1 bit), registered and reset to 0;
  - on the completing edge, ovf <= (carry into bit W-1) XOR cout, i.e. two's-complement signed overflow;
  - ovf updates and holds exactly like sum/cout.
- Undefined: the ovf port and its logic are absent; all other behaviour is identical.

Test Plan (N_NIBBLES=2):
- Basic add: a=0x66, b=0x44, cin=0, start pulse -> busy high 2 cycles; done 1 cycle; sum=0xAA, cout=0.
- Full carry chain: a=0x88, b=0x99, cin=1 -> sum=0x22, cout=1. Also a=0x0F, b=0x01, cin=0 -> sum=0x10, cout=0, exercising the inter-nibble carry.
- Carry-out and back-to-back: a=0xEE, b=0x22, cin=0 -> sum=0x10, cout=1. start held high in the done cycle with a=0x01, b=0x01 -> second done 3 cycles later, sum=0x02, cout=0.
- Start while busy: second start pulse with a=0xFF, b=0xFF during RUN -> ignored; first result unaffected; no extra done.
- Reset mid-op: assert rst one cycle after start -> busy, done, sum and cout go 0 immediately; no done after release; the next start with 0x12+0x34 gives sum=0x46.
- With NIBBLE_SERIAL_ADDER_OVF_EN defined: a=0x70, b=0x10 -> sum=0x80, ovf=1. a=0xF0, b=0x20 -> sum=0x10, cout=1, ovf=0.
